texec_wb: RTL and testbench

Execute-and-writeback stage that sits directly downstream of the 4-entry reservation station. It accepts one issued instruction per cycle: instruction word, writeback tag and two data_width operands. It computes a lane-wise result in a two-stage pipeline, buffers completed results in a small FIFO, and arbitrates them onto the common data bus (CDB) with a request/grant handshake. Its bcast_OUT pulse is the broadcast strobe the reservation station consumes on bcast_IN.

---
 rtl/texec_pkg.sv | 42 ++++
 rtl/tresult_fifo.sv | 68 ++++++
 rtl/texec_wb.sv | 145 ++++++++++++++
 tb/tb_texec_wb.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/texec_pkg.sv
// texec_pkg: shared definitions for the execute/writeback stage.
//   - opcode_e   : lane ALU opcodes OP_ADD .. OP_MOVB (codes 7-15 are unused)
//   - LANE_WIDTH : width of one independent ALU lane
//   - OPCODE_LSB / OPCODE_WIDTH : position of the opcode in the instruction word
//   - lane_op()  : one 32-bit lane of the ALU
package texec_pkg;

    localparam int LANE_WIDTH   = 32;
    localparam int OPCODE_LSB   = 0;
    localparam int OPCODE_WIDTH = 4;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_MOVA = 4'd5,
        OP_MOVB = 4'd6
    } opcode_e;

    // Single lane: ADD/SUB wrap inside the lane, unused opcodes give zero.
    function automatic logic [LANE_WIDTH-1:0] lane_op(
        input logic [OPCODE_WIDTH-1:0] op,
        input logic [LANE_WIDTH-1:0]   a,
        input logic [LANE_WIDTH-1:0]   b
    );
        logic [LANE_WIDTH-1:0] res;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_MOVA: res = a;
            OP_MOVB: res = b;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tresult_fifo.sv
// tresult_fifo: synchronous {tag, data} result FIFO.
//   clk, rst            : clock, asynchronous active-low reset
//   push, push_tag/data : write an entry at the tail
//   pop                 : drop the head entry
//   flush               : empty the FIFO (dominates push and pop)
//   count               : number of stored entries (log2(depth)+1 bits)
//   empty               : count == 0
//   head_tag/head_data  : head entry, forced to zero while empty
module tresult_fifo #(
    parameter int tag_width  = 8,
    parameter int data_width = 128,
    parameter int depth      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [tag_width-1:0]     push_tag,
    input  logic [data_width-1:0]    push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(depth):0]   count,
    output logic                     empty,
    output logic [tag_width-1:0]     head_tag,
    output logic [data_width-1:0]    head_data
);
    localparam int AW = $clog2(depth);

    logic [tag_width-1:0]  r_tag_mem  [depth];
    logic [data_width-1:0] r_data_mem [depth];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            r_tag_mem[r_wr_ptr]  <= push_tag;
            r_data_mem[r_wr_ptr] <= push_data;
        end
    end

    assign count     = r_count;
    assign empty     = (r_count == '0);
    assign head_tag  = empty ? '0 : r_tag_mem[r_rd_ptr];
    assign head_data = empty ? '0 : r_data_mem[r_rd_ptr];

endmodule

// File: rtl/texec_wb.sv
// texec_wb: execute-and-writeback stage behind the reservation station.
//   issue_*   : issued instruction (valid/ready), tag and operands d0/d1
//   flush     : synchronous kill of everything in flight or buffered
//   cdb_*     : request/grant port onto the common data bus
//   bcast_OUT : one-cycle strobe for each result transferred on the CDB
//   busy      : E1, E2 or the result FIFO holds something
// Optional feature: define TEXEC_WB_BYPASS_EN to let E2 drive the CDB
// directly while the FIFO is empty (one cycle less latency).
module texec_wb
    import texec_pkg::*;
#(
    parameter int instr_width = 16,
    parameter int tag_width   = 8,
    parameter int data_width  = 128,
    parameter int fifo_depth  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [instr_width-1:0] issue_instr,
    input  logic [tag_width-1:0]   issue_tag,
    input  logic [data_width-1:0]  issue_d0,
    input  logic [data_width-1:0]  issue_d1,
    input  logic                   flush,
    output logic                   cdb_req,
    input  logic                   cdb_grant,
    output logic [tag_width-1:0]   cdb_tag,
    output logic [data_width-1:0]  cdb_data,
    output logic                   bcast_OUT,
    output logic                   busy
);
    localparam int CW     = $clog2(fifo_depth) + 1;
    localparam int NLANES = data_width / LANE_WIDTH;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(fifo_depth);

    // Handshakes: an issue transfers on a rising edge with issue_valid &
    // issue_ready & ~flush; a result transfers with cdb_req & cdb_grant &
    // ~flush. cdb_req never drops and cdb_tag/cdb_data never change until
    // the transfer happens; a grant without a request means nothing.

    logic                    r_e1_v;
    logic [OPCODE_WIDTH-1:0] r_e1_op;
    logic [tag_width-1:0]    r_e1_tag;
    logic [data_width-1:0]   r_e1_d0;
    logic [data_width-1:0]   r_e1_d1;
    logic                    r_e2_v;
    logic [tag_width-1:0]    r_e2_tag;
    logic [data_width-1:0]   r_e2_res;

    logic [data_width-1:0]   w_alu_res;
    logic [CW-1:0]           w_fifo_count;
    logic                    w_fifo_empty;
    logic [tag_width-1:0]    w_head_tag;
    logic [data_width-1:0]   w_head_data;
    logic [CW:0]             w_inflight;
    logic                    w_issue_fire;
    logic                    w_byp;
    logic                    w_xfer;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_unused_instr;

    // Only the opcode field of the instruction word is meaningful here.
    assign w_unused_instr = ^issue_instr;

    // Registered state only: E2 can always push because the in-flight total
    // never exceeds the FIFO depth.
    assign w_inflight   = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_e1_v}
                        + {{CW{1'b0}}, r_e2_v};
    assign issue_ready  = (w_inflight < DEPTH_L);
    assign w_issue_fire = issue_valid & issue_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_e1_v   <= 1'b0;
            r_e1_op  <= '0;
            r_e1_tag <= '0;
            r_e1_d0  <= '0;
            r_e1_d1  <= '0;
            r_e2_v   <= 1'b0;
            r_e2_tag <= '0;
            r_e2_res <= '0;
        end else begin
            r_e1_v <= w_issue_fire;
            r_e2_v <= r_e1_v & ~flush;
            if (w_issue_fire) begin
                r_e1_op  <= issue_instr[OPCODE_LSB +: OPCODE_WIDTH];
                r_e1_tag <= issue_tag;
                r_e1_d0  <= issue_d0;
                r_e1_d1  <= issue_d1;
            end
            if (r_e1_v) begin
                r_e2_tag <= r_e1_tag;
                r_e2_res <= w_alu_res;
            end
        end
    end

    always_comb begin
        w_alu_res = '0;
        for (int l = 0; l < NLANES; l++) begin
            w_alu_res[l*LANE_WIDTH +: LANE_WIDTH] =
                lane_op(r_e1_op, r_e1_d0[l*LANE_WIDTH +: LANE_WIDTH],
                        r_e1_d1[l*LANE_WIDTH +: LANE_WIDTH]);
        end
    end

`ifdef TEXEC_WB_BYPASS_EN
    assign w_byp = w_fifo_empty & r_e2_v;
`else
    assign w_byp = 1'b0;
`endif

    assign cdb_req   = ~w_fifo_empty | w_byp;
    assign cdb_tag   = w_byp ? r_e2_tag : w_head_tag;
    assign cdb_data  = w_byp ? r_e2_res : w_head_data;
    assign w_xfer    = cdb_req & cdb_grant & ~flush;
    assign bcast_OUT = w_xfer;

    // A bypassed result that is granted never enters the FIFO; an ungranted
    // one is written and reappears unchanged as the FIFO head next cycle.
    assign w_push = r_e2_v & ~flush & ~(w_byp & w_xfer);
    assign w_pop  = w_xfer & ~w_byp;
    assign busy   = r_e1_v | r_e2_v | ~w_fifo_empty;

    tresult_fifo #(
        .tag_width  (tag_width),
        .data_width (data_width),
        .depth      (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_tag  (r_e2_tag),
        .push_data (r_e2_res),
        .pop       (w_pop),
        .flush     (flush),
        .count     (w_fifo_count),
        .empty     (w_fifo_empty),
        .head_tag  (w_head_tag),
        .head_data (w_head_data)
    );

endmodule

// File: tb/tb_texec_wb.sv
// tb_texec_wb: directed self-checking bench for texec_wb (default config,
// or with TEXEC_WB_BYPASS_EN defined for the bypass latency).
module tb_texec_wb;

`ifdef TEXEC_WB_BYPASS_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 3;
`endif

    logic         clk;
    logic         rst;
    logic         issue_valid;
    logic         issue_ready;
    logic [15:0]  issue_instr;
    logic [7:0]   issue_tag;
    logic [127:0] issue_d0;
    logic [127:0] issue_d1;
    logic         flush;
    logic         cdb_req;
    logic         cdb_grant;
    logic [7:0]   cdb_tag;
    logic [127:0] cdb_data;
    logic         bcast_OUT;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_bcast = 0;

    logic [135:0] exp_q[$];

    texec_wb dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_instr (issue_instr),
        .issue_tag   (issue_tag),
        .issue_d0    (issue_d0),
        .issue_d1    (issue_d1),
        .flush       (flush),
        .cdb_req     (cdb_req),
        .cdb_grant   (cdb_grant),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .bcast_OUT   (bcast_OUT),
        .busy        (busy)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic         p_hold = 1'b0;
    logic [7:0]   p_tag;
    logic [127:0] p_data;

    always @(negedge clk) begin
        logic [135:0] e;
        if (bcast_OUT) begin
            if (exp_q.size() == 0) begin
                check("bcast_unexpected", 128'(bcast_OUT), 128'd0);
            end else begin
                e = exp_q.pop_front();
                check("cdb_tag", 128'(cdb_tag), 128'(e[135:128]));
                check("cdb_data", cdb_data, e[127:0]);
                n_bcast++;
            end
        end
        // An ungranted request must be held unchanged into the next cycle.
        if (p_hold && rst) begin
            check("req_hold", 128'(cdb_req), 128'd1);
            check("tag_hold", 128'(cdb_tag), 128'(p_tag));
            check("data_hold", cdb_data, p_data);
        end
        p_hold = cdb_req && !cdb_grant && rst && !flush;
        p_tag  = cdb_tag;
        p_data = cdb_data;
    end

    // ---------------- drivers ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_issue(input logic [3:0] op, input logic [7:0] tag,
                               input logic [127:0] d0, input logic [127:0] d1,
                               input logic [127:0] res);
        int  tries = 0;
        logic acc = 1'b0;
        issue_valid = 1'b1;
        issue_instr = {12'hA5C, op};
        issue_tag   = tag;
        issue_d0    = d0;
        issue_d1    = d1;
        while (!acc && tries < 20) begin
            @(negedge clk);
            if (issue_ready) acc = 1'b1;
            @(posedge clk);
            #1;
            tries++;
        end
        if (acc) exp_q.push_back({tag, res});
        else check("issue_timeout", 128'd0, 128'd1);
        issue_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(name, 128'(exp_q.size()), 128'd0);
    endtask

    localparam logic [15:0] GRANT_PAT = 16'b1011_0010_1110_0101;

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int acc;
        int nb0;
        rst = 1'b0;
        issue_valid = 1'b0;
        issue_instr = '0;
        issue_tag = '0;
        issue_d0 = '0;
        issue_d1 = '0;
        flush = 1'b0;
        cdb_grant = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 128'(issue_ready), 128'd1);
        check("rst_req", 128'(cdb_req), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_bcast", 128'(bcast_OUT), 128'd0);
        check("rst_tag", 128'(cdb_tag), 128'd0);
        check("rst_data", cdb_data, 128'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ADD wrap to zero, grant held high; a grant with no request is ignored
        cdb_grant = 1'b1;
        @(negedge clk);
        check("grant_no_req", 128'(bcast_OUT), 128'd0);
        @(posedge clk);
        #1;
        drive_issue(4'd0, 8'h05, {4{32'hFFFF_FFFF}}, {4{32'h0000_0001}}, 128'd0);
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (bcast_OUT) lat = k;
        end
        check("add_latency", 128'(lat), 128'(EXP_LAT));
        @(posedge clk);
        #1;
        drain("drain_add");

        // Grant low, six consecutive issues: the first four fit
        cdb_grant = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            issue_valid = 1'b1;
            issue_instr = 16'h0005;
            issue_tag   = 8'h20 + 8'(i);
            issue_d0    = {4{24'h00C0DE, 8'(i)}};
            issue_d1    = '0;
            @(negedge clk);
            check($sformatf("fill_ready_%0d", i), 128'(issue_ready), 128'(i < 4));
            if (issue_ready) acc++;
            if (i < 4) exp_q.push_back({8'h20 + 8'(i), {4{24'h00C0DE, 8'(i)}}});
            @(posedge clk);
            #1;
        end
        issue_valid = 1'b0;
        @(negedge clk);
        check("fill_accepts", 128'(acc), 128'd4);
        check("full_ready", 128'(issue_ready), 128'd0);
        check("full_req", 128'(cdb_req), 128'd1);
        check("full_head_tag", 128'(cdb_tag), 128'h20);
        check("full_busy", 128'(busy), 128'd1);
        @(posedge clk);
        #1;
        nb0 = n_bcast;
        cdb_grant = 1'b1;
        drain("drain_fill");
        check("fill_bcasts", 128'(n_bcast - nb0), 128'd4);

        // Opcode vectors, back to back with grant high
        drive_issue(4'd1, 8'h31, {4{32'h1111_1111}}, {4{32'h2222_2222}}, {4{32'hEEEE_EEEF}});
        drive_issue(4'd4, 8'h32, {4{32'h1111_1111}}, {4{32'h2222_2222}}, {4{32'h3333_3333}});
        drive_issue(4'd6, 8'h33, {4{32'h1111_1111}}, {4{32'h2222_2222}}, {4{32'h2222_2222}});
        drive_issue(4'd9, 8'h34, {4{32'h1111_1111}}, {4{32'h2222_2222}}, 128'd0);
        drive_issue(4'd0, 8'h35, {32'hFFFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0010},
                    {32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 32'h0000_0020},
                    {32'h0000_0000, 32'h0000_0003, 32'h8000_0000, 32'h0000_0030});
        drive_issue(4'd0, 8'h36, {4{32'hFF00_FF00}}, {4{32'h0FF0_0FF0}}, {4{32'h0EF1_0EF0}});
        drive_issue(4'd1, 8'h37, {4{32'hFF00_FF00}}, {4{32'h0FF0_0FF0}}, {4{32'hEF10_EF10}});
        drive_issue(4'd2, 8'h38, {4{32'hFF00_FF00}}, {4{32'h0FF0_0FF0}}, {4{32'h0F00_0F00}});
        drive_issue(4'd3, 8'h39, {4{32'hFF00_FF00}}, {4{32'h0FF0_0FF0}}, {4{32'hFFF0_FFF0}});
        drive_issue(4'd5, 8'h3A, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                    {4{32'h0FF0_0FF0}},
                    {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
        drive_issue(4'd6, 8'h3B, {4{32'hFF00_FF00}},
                    {32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555},
                    {32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555});
        drain("drain_ops");

        // Flush with two results buffered and one in E1, grant in the same cycle
        cdb_grant = 1'b0;
        drive_issue(4'd5, 8'h51, {4{32'h0000_0051}}, '0, {4{32'h0000_0051}});
        drive_issue(4'd5, 8'h52, {4{32'h0000_0052}}, '0, {4{32'h0000_0052}});
        @(posedge clk);
        #1;
        drive_issue(4'd5, 8'h53, {4{32'h0000_0053}}, '0, {4{32'h0000_0053}});
        flush = 1'b1;
        cdb_grant = 1'b1;
        @(negedge clk);
        check("flush_req_before", 128'(cdb_req), 128'd1);
        check("flush_no_bcast", 128'(bcast_OUT), 128'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_busy", 128'(busy), 128'd0);
        check("flush_ready", 128'(issue_ready), 128'd1);
        check("flush_req_after", 128'(cdb_req), 128'd0);
        repeat (3) @(negedge clk);
        check("flush_bcast_count", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;

        // Irregular grant with continuous issue: order kept across pointer wrap
        cdb_grant = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++)
                    drive_issue(4'd6, 8'h60 + 8'(i), '1, {16{8'h60 + 8'(i)}}, {16{8'h60 + 8'(i)}});
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    cdb_grant = GRANT_PAT[c % 16];
                    @(posedge clk);
                    #1;
                end
            end
        join
        cdb_grant = 1'b1;
        drain("drain_wrap");

        // Asynchronous reset while a result is waiting
        cdb_grant = 1'b0;
        drive_issue(4'd5, 8'h77, {4{32'h7777_0000}}, '0, {4{32'h7777_0000}});
        lat = 0;
        for (int k = 0; k < 10 && lat == 0; k++) begin
            @(negedge clk);
            if (cdb_req) lat = 1;
        end
        check("req_before_rst", 128'(cdb_req), 128'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_req", 128'(cdb_req), 128'd0);
        check("arst_tag", 128'(cdb_tag), 128'd0);
        check("arst_data", cdb_data, 128'd0);
        check("arst_bcast", 128'(bcast_OUT), 128'd0);
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_ready", 128'(issue_ready), 128'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cdb_grant = 1'b1;
        @(posedge clk);
        #1;
        drive_issue(4'd4, 8'h78, {4{32'h0F0F_0F0F}}, {4{32'hFFFF_0000}}, {4{32'hF0F0_0F0F}});
        drain("drain_post_rst");
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
